// File: rtl/atan2_sched_pkg.sv
// Shared types and constants for the atan2 engine scheduler.
package atan2_sched_pkg;

  localparam int ANGLE_W         = 16;
  localparam int OPERAND_W       = 16;
  // Cycles from eng_start to eng_done for the CORDIC engine in normal operation.
  localparam int ENG_NOMINAL_LAT = 13;

  // One engine operation walks IDLE -> ISSUE -> WAIT -> CAPTURE -> RESP.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT    = 3'd2,
    CAPTURE = 3'd3,
    RESP    = 3'd4
  } state_t;

endpackage

// File: rtl/atan2_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at ptr and wraps modulo N.
// The lowest rotated offset with a pending request wins.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic [N-1:0]                       req,
  input  logic [((N > 1) ? $clog2(N) : 1)-1:0] ptr,
  output logic [N-1:0]                       grant,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] grant_idx,
  output logic                               any
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  // Scan offsets from farthest to nearest so the nearest requester overwrites the others.
  always_comb begin
    int         idx;
    logic [IW-1:0] sel;
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = 0;
    sel       = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N;
      sel = IW'(idx);
      if (req[sel]) begin
        grant_idx = sel;
        any       = 1'b1;
      end
    end
    if (any) begin
      grant[grant_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/atan2_scheduler.sv
// Shares one CORDIC atan2 engine between NREQ requesters. A round-robin grant
// latches one operand pair, runs a single engine operation guarded by a
// watchdog, and returns the angle with a one-hot response strobe.
module atan2_scheduler
  import atan2_sched_pkg::*;
#(
  parameter int NREQ    = 3,
  parameter int TIMEOUT = 31
) (
  input  logic                        clk,
  input  logic                        n_rst,
  input  logic [NREQ-1:0]             req_valid,
  output logic [NREQ-1:0]             req_ready,
  input  logic [OPERAND_W*NREQ-1:0]   req_x,
  input  logic [OPERAND_W*NREQ-1:0]   req_y,
  output logic [NREQ-1:0]             rsp_valid,
  output logic [ANGLE_W-1:0]          rsp_angle,
  output logic                        rsp_err,
  output logic                        busy,
  output logic                        eng_start,
  output logic [OPERAND_W-1:0]        eng_x,
  output logic [OPERAND_W-1:0]        eng_y,
  input  logic [ANGLE_W-1:0]          eng_angle,
  input  logic                        eng_done
);

  localparam int            IW       = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int            CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);

  state_t                state_reg, state_next;
  logic [IW-1:0]         ptr_reg, ptr_next;
  logic [IW-1:0]         id_reg, id_next;
  logic [OPERAND_W-1:0]  x_reg, x_next;
  logic [OPERAND_W-1:0]  y_reg, y_next;
  logic [CW-1:0]         cnt_reg, cnt_next;
  logic [ANGLE_W-1:0]    angle_reg, angle_next;
  logic                  err_reg, err_next;

  logic [NREQ-1:0]       grant;
  logic [IW-1:0]         grant_idx;
  logic                  any_req;
  logic [OPERAND_W-1:0]  x_arr [NREQ];
  logic [OPERAND_W-1:0]  y_arr [NREQ];

  rr_arbiter #(
    .N(NREQ)
  ) u_arb (
    .req      (req_valid),
    .ptr      (ptr_reg),
    .grant    (grant),
    .grant_idx(grant_idx),
    .any      (any_req)
  );

  // Per-requester operand unpacking and one-hot handshake strobes. req_ready is
  // masked by n_rst so nothing is accepted while the block is held in reset.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
    assign x_arr[gi]     = req_x[gi*OPERAND_W +: OPERAND_W];
    assign y_arr[gi]     = req_y[gi*OPERAND_W +: OPERAND_W];
    assign req_ready[gi] = n_rst && (state_reg == IDLE) && grant[gi];
    assign rsp_valid[gi] = (state_reg == RESP) && (id_reg == IW'(gi));
  end

  // Engine operands come straight from the latch so they stay stable all operation.
  assign eng_x     = x_reg;
  assign eng_y     = y_reg;
  assign rsp_angle = angle_reg;
  assign rsp_err   = err_reg;
  assign busy      = (state_reg != IDLE);

  // State and datapath registers; reset clears every register, including mid-operation.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      id_reg    <= '0;
      x_reg     <= '0;
      y_reg     <= '0;
      cnt_reg   <= '0;
      angle_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      id_reg    <= id_next;
      x_reg     <= x_next;
      y_reg     <= y_next;
      cnt_reg   <= cnt_next;
      angle_reg <= angle_next;
      err_reg   <= err_next;
    end
  end

  // Next-state logic: accept, start the engine, wait with watchdog, capture, respond.
  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    id_next    = id_reg;
    x_next     = x_reg;
    y_next     = y_reg;
    cnt_next   = cnt_reg;
    angle_next = angle_reg;
    err_next   = err_reg;
    eng_start  = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (any_req) begin
          x_next     = x_arr[grant_idx];
          y_next     = y_arr[grant_idx];
          id_next    = grant_idx;
          ptr_next   = (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + IW'(1);
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        eng_start  = 1'b1;
        cnt_next   = '0;
        state_next = WAIT;
      end
      WAIT: begin
        // Saturating count; done takes priority over the watchdog in the same cycle.
        if (cnt_reg != CNT_MAX) begin
          cnt_next = cnt_reg + CW'(1);
        end
        if (eng_done) begin
          state_next = CAPTURE;
        end else if (cnt_reg == CNT_LAST) begin
          err_next   = 1'b1;
          angle_next = '0;
          state_next = RESP;
        end
      end
      CAPTURE: begin
        // The engine presents its angle the cycle after done.
        angle_next = eng_angle;
        err_next   = 1'b0;
        state_next = RESP;
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_atan2_scheduler.sv
// Self-checking bench for atan2_scheduler: engine behavioural model, reference
// round-robin/latency model and directed steps with randomized operands.
module tb_atan2_scheduler;

  localparam int NREQ    = 3;
  localparam int TIMEOUT = 31;
  localparam int NOM_LAT = 13;

  logic                 clk = 1'b0;
  logic                 n_rst = 1'b0;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ-1:0]      req_ready;
  logic [16*NREQ-1:0]   req_x = '0;
  logic [16*NREQ-1:0]   req_y = '0;
  logic [NREQ-1:0]      rsp_valid;
  logic [15:0]          rsp_angle;
  logic                 rsp_err;
  logic                 busy;
  logic                 eng_start;
  logic [15:0]          eng_x, eng_y;
  logic [15:0]          eng_angle;
  logic                 eng_done;
  logic                 model_done;
  logic                 inj_done = 1'b0;

  int                   cyc = 0;
  int                   tests = 0;
  int                   fails = 0;
  int                   m_ptr = 0;
  logic [15:0]          held_ang = '0;
  logic                 held_err = 1'b0;
  logic [15:0]          lat_x = '0;
  logic [15:0]          lat_y = '0;
  int                   eng_lat = NOM_LAT;
  int                   ecnt;
  logic [15:0]          ex, ey;
  int                   grant_log[$];

  atan2_scheduler #(
    .NREQ   (NREQ),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_x    (req_x),
    .req_y    (req_y),
    .rsp_valid(rsp_valid),
    .rsp_angle(rsp_angle),
    .rsp_err  (rsp_err),
    .busy     (busy),
    .eng_start(eng_start),
    .eng_x    (eng_x),
    .eng_y    (eng_y),
    .eng_angle(eng_angle),
    .eng_done (eng_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in result of the engine: any fixed function of the operands will do.
  function automatic logic [15:0] eng_func(input logic [15:0] x, input logic [15:0] y);
    return 16'(x + y * 16'd44);
  endfunction

  // Engine model: done pulses eng_lat edges after start (0 = never), angle valid one cycle later.
  assign eng_done = model_done | inj_done;
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ecnt       <= 0;
      model_done <= 1'b0;
      eng_angle  <= '0;
      ex         <= '0;
      ey         <= '0;
    end else begin
      model_done <= 1'b0;
      eng_angle  <= eng_done ? eng_func(ex, ey) : ~eng_func(ex, ey);
      if (eng_start) begin
        ex   <= eng_x;
        ey   <= eng_y;
        ecnt <= (eng_lat > 0) ? eng_lat - 1 : 0;
      end else if (ecnt == 1) begin
        model_done <= 1'b1;
        ecnt       <= 0;
      end else if (ecnt > 1) begin
        ecnt <= ecnt - 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $display("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int onehot(input int i);
    return 1 << i;
  endfunction

  // Reference arbitration: first valid requester at or after m_ptr, wrapping.
  function automatic int rr_pick(input logic [NREQ-1:0] v);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  // Drive requests and check every cycle against the reference model until n_ops responses.
  task automatic serve(input int n_ops, input logic [NREQ-1:0] vmask, input bit drop, input int raise_id);
    int          got_n = 0;
    int          budget = n_ops * (TIMEOUT + 8) + 20;
    int          pend = -1;
    int          acc = 0;
    int          rsp_at = 0;
    int          idle_from = 0;
    int          upd = -1;
    int          g;
    int          obs;
    bit          first = 1'b1;
    logic [15:0] pang = '0;
    logic        perr = 1'b0;
    while (got_n < n_ops) begin
      if (budget == 0) begin
        chk("serve_budget", 32'(got_n), 32'(n_ops));
        break;
      end
      budget--;
      @(negedge clk);
      if (first) begin
        req_valid = vmask;
        first     = 1'b0;
      end
      if (upd >= 0) begin
        if (drop) begin
          req_valid[upd] = 1'b0;
        end else begin
          req_x[upd*16 +: 16] = 16'($urandom);
          req_y[upd*16 +: 16] = 16'($urandom);
        end
        upd = -1;
      end
      if (raise_id >= 0 && pend >= 0 && pend != raise_id && cyc == acc + 5) begin
        req_valid[raise_id] = 1'b1;
      end
      #1;
      chk("busy", 32'(busy), 32'(pend >= 0 && cyc > acc));
      chk("eng_start", 32'(eng_start), 32'(pend >= 0 && cyc == acc + 1));
      chk("eng_x", 32'(eng_x), 32'(lat_x));
      chk("eng_y", 32'(eng_y), 32'(lat_y));
      if (pend >= 0 && cyc == rsp_at) begin
        held_ang = pang;
        held_err = perr;
      end
      chk("rsp_valid", 32'(rsp_valid), (pend >= 0 && cyc == rsp_at) ? onehot(pend) : 0);
      chk("rsp_angle", 32'(rsp_angle), 32'(held_ang));
      chk("rsp_err", 32'(rsp_err), 32'(held_err));
      g = (pend < 0 && cyc >= idle_from) ? rr_pick(req_valid) : -1;
      chk("req_ready", 32'(req_ready), (g >= 0) ? onehot(g) : 0);
      if (pend >= 0 && cyc == rsp_at) begin
        $display("[TB] op: requester %0d x=%04h y=%04h angle=%04h err=%0d latency=%0d",
                 pend, lat_x, lat_y, rsp_angle, rsp_err, cyc - acc);
        got_n++;
        pend      = -1;
        idle_from = cyc + 1;
      end
      if (g >= 0) begin
        obs = -1;
        for (int k = 0; k < NREQ; k++) if (req_ready[k]) obs = k;
        grant_log.push_back(obs);
        pend   = g;
        acc    = cyc;
        lat_x  = req_x[g*16 +: 16];
        lat_y  = req_y[g*16 +: 16];
        perr   = (eng_lat == 0 || eng_lat > TIMEOUT);
        pang   = perr ? 16'h0000 : eng_func(lat_x, lat_y);
        rsp_at = perr ? acc + TIMEOUT + 2 : acc + eng_lat + 3;
        m_ptr  = (g + 1) % NREQ;
        upd    = g;
      end
    end
    req_valid = '0;
  endtask

  // Idle cycles with no requests: nothing may respond and outputs must hold.
  task automatic idle_quiet(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
      chk("quiet_rsp_valid", 32'(rsp_valid), 32'(0));
      chk("quiet_busy", 32'(busy), 32'(0));
      chk("quiet_angle", 32'(rsp_angle), 32'(held_ang));
      chk("quiet_err", 32'(rsp_err), 32'(held_err));
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'(0));
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(0));
    chk({tag, "_rsp_angle"}, 32'(rsp_angle), 32'(0));
    chk({tag, "_rsp_err"}, 32'(rsp_err), 32'(0));
    chk({tag, "_busy"}, 32'(busy), 32'(0));
    chk({tag, "_eng_start"}, 32'(eng_start), 32'(0));
    chk({tag, "_eng_x"}, 32'(eng_x), 32'(0));
    chk({tag, "_eng_y"}, 32'(eng_y), 32'(0));
  endtask

  initial begin
    // Reset state, with requests asserted to confirm nothing is accepted.
    req_valid = '1;
    repeat (3) @(negedge clk);
    #1;
    chk_all_zero("reset");
    req_valid = '0;
    @(negedge clk);
    n_rst = 1'b1;

    // Fairness: all requesters permanently valid, random operands.
    for (int i = 0; i < NREQ; i++) begin
      req_x[i*16 +: 16] = 16'($urandom);
      req_y[i*16 +: 16] = 16'($urandom);
    end
    grant_log.delete();
    serve(6, 3'b111, 1'b0, -1);
    chk("grant_count", 32'(grant_log.size()), 32'(6));
    for (int i = 0; i < 6; i++) begin
      if (i < grant_log.size()) chk("grant_order", 32'(grant_log[i]), 32'(i % NREQ));
    end

    // Single request from requester 1, nominal latency.
    eng_lat = NOM_LAT;
    req_x[16 +: 16] = 16'd256;
    req_y[16 +: 16] = 16'd256;
    serve(1, 3'b010, 1'b1, -1);
    chk("single_angle", 32'(rsp_angle), 32'h2D00);
    chk("single_err", 32'(rsp_err), 32'(0));

    // Engine never answers: watchdog abort, then a stray done while idle.
    eng_lat = 0;
    req_x[0 +: 16] = 16'($urandom);
    req_y[0 +: 16] = 16'($urandom);
    serve(1, 3'b001, 1'b1, -1);
    chk("timeout_err", 32'(rsp_err), 32'(1));
    chk("timeout_angle", 32'(rsp_angle), 32'(0));
    @(negedge clk);
    inj_done = 1'b1;
    @(negedge clk);
    inj_done = 1'b0;
    idle_quiet(6);

    // Engine answers only after the abort: the late done must be dropped.
    eng_lat = 40;
    req_x[32 +: 16] = 16'($urandom);
    req_y[32 +: 16] = 16'($urandom);
    serve(1, 3'b100, 1'b1, -1);
    idle_quiet(15);

    // Done on the final watchdog cycle: done wins.
    eng_lat = TIMEOUT;
    req_x[16 +: 16] = 16'($urandom);
    req_y[16 +: 16] = 16'($urandom);
    serve(1, 3'b010, 1'b1, -1);
    chk("coincide_err", 32'(rsp_err), 32'(0));

    // Reset asserted while waiting on the engine.
    eng_lat = NOM_LAT;
    @(negedge clk);
    req_x[0 +: 16] = 16'($urandom | 1);
    req_valid = 3'b001;
    #1;
    chk("rst_pre_ready", 32'(req_ready), 32'(3'b001));
    @(negedge clk);
    req_valid = '0;
    repeat (4) @(negedge clk);
    #1;
    chk("rst_pre_busy", 32'(busy), 32'(1));
    req_valid = 3'b011;
    n_rst = 1'b0;
    #1;
    chk_all_zero("midrst");
    m_ptr    = 0;
    held_ang = '0;
    held_err = 1'b0;
    lat_x    = '0;
    lat_y    = '0;
    @(negedge clk);
    req_valid = '0;
    n_rst = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      req_x[i*16 +: 16] = 16'($urandom);
      req_y[i*16 +: 16] = 16'($urandom);
    end
    serve(2, 3'b011, 1'b1, -1);
    serve(1, 3'b100, 1'b1, -1);

    // Requester 0 raises while requester 2 is in flight and is served next.
    req_x[0 +: 16] = 16'hFF00;
    req_y[0 +: 16] = 16'h0000;
    req_x[32 +: 16] = 16'($urandom);
    req_y[32 +: 16] = 16'($urandom);
    grant_log.delete();
    serve(2, 3'b100, 1'b1, 0);
    chk("raise_count", 32'(grant_log.size()), 32'(2));
    if (grant_log.size() == 2) begin
      chk("raise_first", 32'(grant_log[0]), 32'(2));
      chk("raise_second", 32'(grant_log[1]), 32'(0));
    end
    chk("raise_eng_x", 32'(eng_x), 32'h0000FF00);
    chk("raise_eng_y", 32'(eng_y), 32'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
